// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - command/response bundle between an SPI transfer initiator and spi_master_ctrl
interface spi_master_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 5,
    parameter int DIV_W  = 8
);
    logic              start;
    logic              ready;
    logic [LEN_W-1:0]  len;
    logic [DIV_W-1:0]  div;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic              done;

    modport master (
        output start, len, div, tx_data,
        input  ready, rx_data, done
    );

    modport slave (
        input  start, len, div, tx_data,
        output ready, rx_data, done
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode-0 master, MSB-first full duplex, single slave select
module spi_master_ctrl #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 5,
    parameter int DIV_W  = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    spi_master_ctrl_if.slave cmd,
    output logic             sck,
    output logic             ss_n,
    output logic             mosi,
    input  logic             miso
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, HOLD} state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);

    state_t            state;
    logic              ready_q;
    logic              done_q;
    logic [DATA_W-1:0] rx_data_q;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] tx_sr;
    logic [LEN_W-1:0]  bit_cnt;
    logic [DIV_W-1:0]  phase_cnt;
    logic [DIV_W-1:0]  div_q;

    logic [LEN_W-1:0]  len_c;
    logic [DATA_W-1:0] tx_aligned;
    logic              phase_end;

    // Left-align the command so the next bit to send is always tx_sr[DATA_W-1].
    assign len_c      = (cmd.len > LEN_MAX) ? LEN_MAX : cmd.len;
    assign tx_aligned = cmd.tx_data << (LEN_MAX - len_c);
    assign phase_end  = (phase_cnt == div_q);

    assign cmd.ready   = ready_q;
    assign cmd.done    = done_q;
    assign cmd.rx_data = rx_data_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            rx_data_q <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            bit_cnt   <= '0;
            phase_cnt <= '0;
            div_q     <= '0;
            sck       <= 1'b0;
            ss_n      <= 1'b1;
            mosi      <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd.start) begin
                        if (len_c == '0) begin
                            done_q    <= 1'b1;
                            rx_data_q <= '0;
                        end else begin
                            tx_sr     <= tx_aligned << 1;
                            mosi      <= tx_aligned[DATA_W-1];
                            bit_cnt   <= len_c;
                            div_q     <= cmd.div;
                            phase_cnt <= '0;
                            rx_sr     <= '0;
                            ss_n      <= 1'b0;
                            sck       <= 1'b0;
                            ready_q   <= 1'b0;
                            state     <= LOW;
                        end
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        phase_cnt <= '0;
                        sck       <= 1'b1;
                        rx_sr     <= {rx_sr[DATA_W-2:0], miso};
                        state     <= HIGH;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        phase_cnt <= '0;
                        sck       <= 1'b0;
                        bit_cnt   <= bit_cnt - 1'b1;
                        if (bit_cnt > LEN_W'(1)) begin
                            mosi  <= tx_sr[DATA_W-1];
                            tx_sr <= tx_sr << 1;
                            state <= LOW;
                        end else begin
                            state <= HOLD;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (phase_end) begin
                        phase_cnt <= '0;
                        ss_n      <= 1'b1;
                        mosi      <= 1'b1;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_sr;
                        ready_q   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - scoreboard bench for spi_master_ctrl
module tb_spi_master_ctrl;
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic sck, ss_n, mosi, miso;
    logic loopback = 1'b0;
    logic miso_fix = 1'b0;

    always #5 clock = ~clock;
    assign miso = loopback ? mosi : miso_fix;

    spi_master_ctrl_if cmd ();

    spi_master_ctrl dut (
        .clock (clock),
        .rst_n (rst_n),
        .cmd   (cmd),
        .sck   (sck),
        .ss_n  (ss_n),
        .mosi  (mosi),
        .miso  (miso)
    );

    typedef struct {
        logic [15:0] rx;
        int          low;
        int          rise;
        logic [15:0] mosi_bits;
        int          half;
    } exp_t;

    exp_t exp_q[$];
    int   vecs  = 0;
    int   fails = 0;

    int          acc_low, acc_rise, hi_run, viol;
    logic [15:0] acc_mosi;
    logic        prev_sck, prev_mosi;

    task automatic chk(input string name, input int act, input int req);
        vecs++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic clear_acc();
        acc_low   = 0;
        acc_rise  = 0;
        hi_run    = 0;
        viol      = 0;
        acc_mosi  = '0;
        prev_sck  = 1'b0;
        prev_mosi = 1'b1;
    endtask

    task automatic monitor();
        exp_t e;
        clear_acc();
        forever begin
            @(negedge clock);
            if (!rst_n) begin
                clear_acc();
                continue;
            end
            if (!ss_n) acc_low++;
            if (sck && !prev_sck) begin
                acc_rise++;
                acc_mosi = {acc_mosi[14:0], mosi};
                hi_run   = 1;
            end else if (sck) begin
                hi_run++;
            end
            if (!sck && prev_sck && exp_q.size() > 0) chk("sck_high_cycles", hi_run, exp_q[0].half);
            if (mosi != prev_mosi && sck) viol++;
            prev_sck  = sck;
            prev_mosi = mosi;
            if (cmd.done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rx_data", int'(cmd.rx_data), int'(e.rx));
                    chk("ss_n_low_cycles", acc_low, e.low);
                    chk("sck_rises", acc_rise, e.rise);
                    chk("mosi_bits", int'(acc_mosi), int'(e.mosi_bits));
                    chk("mosi_change_while_sck_high", viol, 0);
                end
                clear_acc();
            end
        end
    endtask

    task automatic issue(input logic [15:0] tx, input logic [4:0] l, input logic [7:0] d,
                         input bit exp_done, input logic [15:0] e_rx, input int e_low,
                         input int e_rise, input logic [15:0] e_mosi);
        int n = 0;
        exp_t e;
        while (!cmd.ready && n < 5000) begin
            @(posedge clock); #1;
            n++;
        end
        chk("ready_before_start", int'(cmd.ready), 1);
        cmd.tx_data = tx;
        cmd.len     = l;
        cmd.div     = d;
        cmd.start   = 1'b1;
        if (exp_done) begin
            e.rx = e_rx; e.low = e_low; e.rise = e_rise; e.mosi_bits = e_mosi; e.half = int'(d) + 1;
            exp_q.push_back(e);
        end
        @(posedge clock); #1;
        cmd.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 5000) begin
            @(posedge clock); #1;
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic stimulus();
        int n;
        cmd.start = 1'b0; cmd.len = '0; cmd.div = '0; cmd.tx_data = '0;
        #12;
        chk("rst_ready", int'(cmd.ready), 1);
        chk("rst_done", int'(cmd.done), 0);
        chk("rst_sck", int'(sck), 0);
        chk("rst_ss_n", int'(ss_n), 1);
        chk("rst_mosi", int'(mosi), 1);
        chk("rst_rx_data", int'(cmd.rx_data), 0);
        @(posedge clock); #1;
        rst_n = 1'b1;
        @(posedge clock); #1;

        // loopback byte at full speed
        loopback = 1'b1;
        issue(16'h00A5, 5'd8, 8'd0, 1'b1, 16'h00A5, 17, 8, 16'h00A5);
        drain();

        // miso high, 16 bits, div 3
        loopback = 1'b0; miso_fix = 1'b1;
        issue(16'h1234, 5'd16, 8'd3, 1'b1, 16'hFFFF, 132, 16, 16'h1234);
        drain();

        // start while busy must be ignored
        loopback = 1'b1;
        issue(16'h003C, 5'd8, 8'd1, 1'b1, 16'h003C, 34, 8, 16'h003C);
        repeat (5) begin @(posedge clock); #1; end
        cmd.tx_data = 16'h00FF; cmd.start = 1'b1;
        @(posedge clock); #1;
        cmd.start = 1'b0;
        chk("busy_ready_low", int'(cmd.ready), 0);
        drain();
        repeat (60) begin @(posedge clock); #1; end

        // zero-length command
        issue(16'hFFFF, 5'd0, 8'd0, 1'b1, 16'h0000, 0, 0, 16'h0000);
        chk("len0_done", int'(cmd.done), 1);
        chk("len0_ss_n", int'(ss_n), 1);
        drain();

        // reset after three bits
        issue(16'h005A, 5'd8, 8'd0, 1'b0, 16'h0000, 0, 0, 16'h0000);
        n = 0;
        while (acc_rise < 3 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        chk("abort_reached_bit3", acc_rise, 3);
        rst_n = 1'b0;
        #1;
        chk("abort_ss_n", int'(ss_n), 1);
        chk("abort_sck", int'(sck), 0);
        chk("abort_mosi", int'(mosi), 1);
        chk("abort_ready", int'(cmd.ready), 1);
        chk("abort_done", int'(cmd.done), 0);
        repeat (2) begin @(posedge clock); #1; end
        rst_n = 1'b1;
        @(posedge clock); #1;
        issue(16'h00C3, 5'd8, 8'd0, 1'b1, 16'h00C3, 17, 8, 16'h00C3);
        drain();

        // len above DATA_W clamps to 16
        issue(16'hA5A5, 5'd20, 8'd0, 1'b1, 16'hA5A5, 33, 16, 16'hA5A5);
        drain();

        // maximum divider
        loopback = 1'b0; miso_fix = 1'b1;
        issue(16'h0002, 5'd2, 8'd255, 1'b1, 16'h0003, 1280, 2, 16'h0002);
        drain();

        // back-to-back: second start in the done cycle
        miso_fix = 1'b0;
        issue(16'h0001, 5'd1, 8'd0, 1'b1, 16'h0000, 3, 1, 16'h0001);
        n = 0;
        while (!cmd.done && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        chk("b2b_done_seen", int'(cmd.done), 1);
        chk("b2b_gap_ss_n", int'(ss_n), 1);
        issue(16'h0001, 5'd1, 8'd0, 1'b1, 16'h0000, 3, 1, 16'h0001);
        chk("b2b_accept_ss_n", int'(ss_n), 0);
        drain();
        repeat (10) begin @(posedge clock); #1; end
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
